// File: rtl/triple_stim_gen.sv
// triple_stim_gen: Galois-LFSR source of (A,B,C) operand triples over a valid/ready handshake.
// Optional running operand sum on sum_out when STIM_SUM_EN is defined.
module triple_stim_gen #(
  parameter int unsigned N = 5,
  parameter int unsigned LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1,
  parameter int unsigned COUNT = 15,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic ready_in,
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [N-1:0] C,
  output logic valid,
  output logic [CNT_W-1:0] idx,
  output logic busy,
  output logic done,
  output logic [2*N-1:0] sum_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q;
  logic [LFSR_W-1:0] lfsr_q, step_d, seed_d;
  logic [N-1:0] a_q, b_q, c_q;
  logic [CNT_W-1:0] idx_q;
  logic valid_q, busy_q, done_q, pend_q;
  logic launch, xfer, last, idle;
  always_comb begin
    step_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    seed_d = (seed == '0) ? SEED : seed;
    idle = state_q != RUN;
    xfer = !idle && valid_q && ready_in;
    last = idx_q == CNT_W'(COUNT - 1);
    launch = idle && !seed_load && (start || pend_q);
  end
  // A start coinciding with seed_load is remembered and launches the run next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q <= SEED;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      idx_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      pend_q <= idle && seed_load && (start || pend_q);
      if (idle && seed_load) begin
        lfsr_q <= seed_d;
      end else if (launch || (xfer && !last)) begin
        lfsr_q <= step_d;
        a_q <= step_d[N-1:0];
        b_q <= step_d[2*N-1:N];
        c_q <= step_d[3*N-1:2*N];
      end
      if (launch) begin
        state_q <= RUN;
        valid_q <= 1'b1;
        busy_q <= 1'b1;
        done_q <= 1'b0;
        idx_q <= '0;
      end else if (xfer) begin
        if (last) begin
          state_q <= DONE;
          valid_q <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end
  assign A = a_q;
  assign B = b_q;
  assign C = c_q;
  assign idx = idx_q;
  assign valid = valid_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef STIM_SUM_EN
  localparam int unsigned SW = 2 * N;
  logic [SW-1:0] sum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else if (launch) sum_q <= '0;
    else if (xfer) sum_q <= sum_q + SW'(a_q) + SW'(b_q) + SW'(c_q);
  end
  assign sum_out = sum_q;
`else
  assign sum_out = '0;
`endif
endmodule

// File: tb/tb_triple_stim_gen.sv
// tb_triple_stim_gen: randomized handshake stimulus against a queue-free LFSR reference model.
module tb_triple_stim_gen;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start0 = 1'b0, seed_load0 = 1'b0, ready0 = 1'b0;
  logic [15:0] seed0 = '0;
  logic start1 = 1'b0, ready1 = 1'b0, seed_load1 = 1'b0;
  logic [15:0] seed1 = '0;
  logic [4:0] A0, B0, C0, A1, B1, C1;
  logic [7:0] idx0, idx1;
  logic valid0, busy0, done0, valid1, busy1, done1;
  logic [9:0] sum0, sum1;
  int checks = 0, errors = 0;
  logic [15:0] m_lfsr;
  int m_idx, m_sum;

  triple_stim_gen u0 (.clk(clk), .rst_n(rst_n), .start(start0), .seed_load(seed_load0), .seed(seed0),
    .ready_in(ready0), .A(A0), .B(B0), .C(C0), .valid(valid0), .idx(idx0), .busy(busy0), .done(done0),
    .sum_out(sum0));
  triple_stim_gen #(.COUNT(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .seed_load(seed_load1),
    .seed(seed1), .ready_in(ready1), .A(A1), .B(B1), .C(C1), .valid(valid1), .idx(idx1), .busy(busy1),
    .done(done1), .sum_out(sum1));

  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [15:0] nxt(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction
  function automatic int tsum(input logic [15:0] x);
    return int'(x[4:0]) + int'(x[9:5]) + int'(x[14:10]);
  endfunction
  function automatic logic [9:0] exp_sum(input int s);
`ifdef STIM_SUM_EN
    return 10'(s % 1024);
`else
    return 10'(s * 0);
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++; if ({A0, B0, C0} !== 15'd0) begin errors++; $display("FAIL reset_abc got %h exp 0", {A0, B0, C0}); end
    checks++; if ({valid0, busy0, done0} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {valid0, busy0, done0}); end
    checks++; if (idx0 !== 8'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", idx0); end
    checks++; if (sum0 !== 10'd0) begin errors++; $display("FAIL reset_sum got %0d exp 0", sum0); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_lfsr = 16'hACE1;
  endtask

  task automatic test_count_one;
    start1 = 1'b1; ready1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++; if ({valid1, A1, B1, C1} !== {1'b1, 5'd16, 5'd19, 5'd24}) begin errors++; $display("FAIL c1_triple got %b/%0d/%0d/%0d exp 1/16/19/24", valid1, A1, B1, C1); end
    tick();
    ready1 = 1'b0;
    checks++; if ({valid1, busy1, done1} !== 3'b001) begin errors++; $display("FAIL c1_done got %b exp 001", {valid1, busy1, done1}); end
    checks++; if (idx1 !== 8'd0) begin errors++; $display("FAIL c1_idx got %0d exp 0", idx1); end
    checks++; if (sum1 !== exp_sum(59)) begin errors++; $display("FAIL c1_sum got %0d exp %0d", sum1, exp_sum(59)); end
  endtask

  task automatic test_first_triple;
    ready0 = 1'b0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    m_lfsr = nxt(m_lfsr); m_idx = 0; m_sum = 0;
    checks++; if ({valid0, busy0, done0} !== 3'b110) begin errors++; $display("FAIL first_flags got %b exp 110", {valid0, busy0, done0}); end
    checks++; if (idx0 !== 8'd0) begin errors++; $display("FAIL first_idx got %0d exp 0", idx0); end
    checks++; if ({A0, B0, C0} !== {5'd16, 5'd19, 5'd24}) begin errors++; $display("FAIL first_abc got %0d/%0d/%0d exp 16/19/24", A0, B0, C0); end
  endtask

  task automatic check_done_state(input string tag);
    checks++; if ({valid0, busy0, done0} !== 3'b001) begin errors++; $display("FAIL %s_flags got %b exp 001", tag, {valid0, busy0, done0}); end
    checks++; if (idx0 !== 8'd14) begin errors++; $display("FAIL %s_idx got %0d exp 14", tag, idx0); end
    checks++; if ({C0, B0, A0} !== m_lfsr[14:0]) begin errors++; $display("FAIL %s_hold got %h exp %h", tag, {C0, B0, A0}, m_lfsr[14:0]); end
    checks++; if (sum0 !== exp_sum(m_sum)) begin errors++; $display("FAIL %s_sum got %0d exp %0d", tag, sum0, exp_sum(m_sum)); end
  endtask

  task automatic test_stall;
    int stall = 0;
    bit fin = 1'b0;
    logic r;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      r = (m_idx == 5 && stall < 5) ? 1'b0 : 1'($urandom % 2);
      if (m_idx == 5 && !r) stall++;
      ready0 = r;
      start0 = ($urandom % 4) == 0;
      seed_load0 = ($urandom % 4) == 0;
      seed0 = 16'($urandom);
      checks++; if ({valid0, busy0, idx0} !== {2'b11, 8'(m_idx)}) begin errors++; $display("FAIL stall_hs got v%b b%b i%0d exp v1 b1 i%0d", valid0, busy0, idx0, m_idx); end
      checks++; if ({C0, B0, A0} !== m_lfsr[14:0]) begin errors++; $display("FAIL stall_abc idx %0d got %h exp %h", m_idx, {C0, B0, A0}, m_lfsr[14:0]); end
      tick();
      if (r) begin
        m_sum += tsum(m_lfsr);
        if (m_idx == 14) fin = 1'b1;
        else begin m_idx++; m_lfsr = nxt(m_lfsr); end
      end
    end
    start0 = 1'b0; seed_load0 = 1'b0; ready0 = 1'b0;
    checks++; if (!fin || stall < 5) begin errors++; $display("FAIL stall_budget got fin=%0d stall=%0d exp fin=1 stall=5", fin, stall); end
    check_done_state("stall_end");
  endtask

  task automatic test_done_idle;
    ready0 = 1'b1;
    repeat (4) begin
      tick();
      check_done_state("done_idle");
    end
    ready0 = 1'b0;
  endtask

  task automatic test_full_run;
    ready0 = 1'b1; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    m_lfsr = nxt(m_lfsr); m_sum = 0;
    for (int k = 0; k < 15; k++) begin
      checks++; if ({valid0, idx0} !== {1'b1, 8'(k)}) begin errors++; $display("FAIL b2b_idx got v%b i%0d exp v1 i%0d", valid0, idx0, k); end
      checks++; if ({C0, B0, A0} !== m_lfsr[14:0]) begin errors++; $display("FAIL b2b_abc idx %0d got %h exp %h", k, {C0, B0, A0}, m_lfsr[14:0]); end
      m_sum += tsum(m_lfsr);
      tick();
      if (k < 14) m_lfsr = nxt(m_lfsr);
    end
    ready0 = 1'b0;
    check_done_state("b2b_end");
  endtask

  task automatic test_seed;
    seed_load0 = 1'b1; seed0 = 16'h0000;
    tick();
    seed_load0 = 1'b0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    checks++; if ({valid0, A0, B0, C0} !== {1'b1, 5'd16, 5'd19, 5'd24}) begin errors++; $display("FAIL seed0_abc got %b/%0d/%0d/%0d exp 1/16/19/24", valid0, A0, B0, C0); end
    ready0 = 1'b1;
    repeat (15) tick();
    ready0 = 1'b0;
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL seed0_drain got %b exp 1", done0); end
    seed_load0 = 1'b1; seed0 = 16'h0001; start0 = 1'b1;
    tick();
    seed_load0 = 1'b0;
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL seed1_defer got %b exp 0", valid0); end
    tick();
    start0 = 1'b0;
    checks++; if ({valid0, A0, B0, C0} !== {1'b1, 5'd0, 5'd0, 5'd13}) begin errors++; $display("FAIL seed1_abc got %b/%0d/%0d/%0d exp 1/0/0/13", valid0, A0, B0, C0); end
    m_lfsr = 16'hB400; m_idx = 0; m_sum = 0;
  endtask

  task automatic test_reset_midrun;
    ready0 = 1'b1; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (7) tick();
    checks++; if (idx0 !== 8'd7) begin errors++; $display("FAIL mid_idx got %0d exp 7", idx0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({A0, B0, C0, idx0, sum0} !== '0) begin errors++; $display("FAIL mid_rst_data got %h exp 0", {A0, B0, C0, idx0, sum0}); end
    checks++; if ({valid0, busy0, done0} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags got %b exp 000", {valid0, busy0, done0}); end
    ready0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_lfsr = 16'hACE1;
  endtask

  initial begin
    test_reset();
    test_count_one();
    test_first_triple();
    test_stall();
    test_done_idle();
    test_full_run();
    test_seed();
    test_stall();
    test_reset_midrun();
    test_full_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
